// File: rtl/sys_reset_seq.sv
// sys_reset_seq: synchronised, staggered release of N_CH reset domains, run-cycle
// counting, and end-of-run detection on CPU halt or watchdog expiry.
module sys_reset_seq #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned STAGGER     = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TIMEOUT     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             soft_rst,
   input  logic             halt,
   output logic [N_CH-1:0]  rst_out,
   output logic             run,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int unsigned      LAST_REL = HOLD_CYCLES + (N_CH - 1) * STAGGER;
   localparam int unsigned      SEQ_W    = $clog2(LAST_REL + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_SYNC, S_HOLD, S_RUN, S_DONE} state_t;

   state_t           r_state,   w_state_nxt;
   logic [1:0]       r_sync;
   logic [SEQ_W-1:0] r_seq,     w_seq_nxt;
   logic             r_restart, w_restart_nxt;
   logic [N_CH-1:0]  r_rst_out, w_rst_out_nxt;
   logic             r_run,     w_run_nxt;
   logic             r_done,    w_done_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;

   // State and output registers; the sync chain shifts in 0 once reset drops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync    <= 2'b11;
         r_state   <= S_SYNC;
         r_seq     <= '0;
         r_restart <= 1'b0;
         r_rst_out <= '1;
         r_run     <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], 1'b0};
         r_state   <= w_state_nxt;
         r_seq     <= w_seq_nxt;
         r_restart <= w_restart_nxt;
         r_rst_out <= w_rst_out_nxt;
         r_run     <= w_run_nxt;
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_seq_nxt     = r_seq;
      w_restart_nxt = r_restart;
      w_rst_out_nxt = r_rst_out;
      w_run_nxt     = r_run;
      w_done_nxt    = r_done;
      w_timeout_nxt = r_timeout;
      w_cnt_nxt     = r_cnt;

      case (r_state)
         S_SYNC: begin
            if (!r_sync[1]) begin
               w_state_nxt = S_HOLD;
               w_seq_nxt   = '0;
            end
         end
         S_HOLD: begin
            // After a soft restart the first edge with soft_rst low is T0: hold the count there
            if (r_restart) begin
               w_restart_nxt = 1'b0;
            end else begin
               w_seq_nxt = r_seq + SEQ_W'(1);
               for (int unsigned i = 0; i < N_CH; i++) begin
                  w_rst_out_nxt[i] = r_rst_out[i] &
                                     (w_seq_nxt < SEQ_W'(HOLD_CYCLES + i * STAGGER));
               end
               if (w_seq_nxt == SEQ_W'(LAST_REL)) begin
                  w_state_nxt = S_RUN;
                  w_run_nxt   = 1'b1;
               end
            end
         end
         S_RUN: begin
            w_cnt_nxt = w_cnt_inc;
            if (halt) begin
               w_state_nxt = S_DONE;
               w_run_nxt   = 1'b0;
               w_done_nxt  = 1'b1;
            end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
               w_state_nxt   = S_DONE;
               w_run_nxt     = 1'b0;
               w_done_nxt    = 1'b1;
               w_timeout_nxt = 1'b1;
            end
         end
         default: begin
         end
      endcase

      // Re-sequence request overrides everything except the initial synchroniser wait
      if (soft_rst && (r_state != S_SYNC)) begin
         w_state_nxt   = S_HOLD;
         w_seq_nxt     = '0;
         w_restart_nxt = 1'b1;
         w_rst_out_nxt = '1;
         w_run_nxt     = 1'b0;
         w_done_nxt    = 1'b0;
         w_timeout_nxt = 1'b0;
         w_cnt_nxt     = '0;
      end
   end

   assign rst_out   = r_rst_out;
   assign run       = r_run;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Bench for sys_reset_seq: three configurations driven by shared reset/soft_rst,
// per-cycle scoreboard against a timing-rule reference model plus spot checks.
module tb_sys_reset_seq;

   localparam int ND = 3;

   typedef struct packed {
      logic [3:0]  rst;
      logic        run;
      logic        done;
      logic        to;
      logic [31:0] cnt;
   } obs_t;

   typedef struct {
      bit     in_sync;
      int     since_rel;
      bit     waiting;
      bit     active;
      int     k;
      longint cnt;
      bit     done;
      bit     to;
   } mdl_t;

   logic clk = 1'b0;
   logic reset, soft_rst, halt_a, halt_b, halt_c;

   logic [3:0]  a_rst;  logic a_run, a_done, a_to;  logic [31:0] a_cnt;
   logic [3:0]  b_rst;  logic b_run, b_done, b_to;  logic [31:0] b_cnt;
   logic        c_rst;  logic c_run, c_done, c_to;  logic [7:0]  c_cnt;

   int     P_N   [ND] = '{4, 4, 1};
   int     P_H   [ND] = '{8, 8, 8};
   int     P_S   [ND] = '{2, 2, 0};
   int     P_TO  [ND] = '{0, 50, 0};
   longint P_MAX [ND] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd255};

   mdl_t m [ND];
   obs_t q [ND][$];
   int   n_tests = 0;
   int   n_fail  = 0;

   sys_reset_seq #(.N_CH(4), .HOLD_CYCLES(8), .STAGGER(2), .CNT_W(32), .TIMEOUT(0)) dut_a (
      .clk(clk), .reset(reset), .soft_rst(soft_rst), .halt(halt_a),
      .rst_out(a_rst), .run(a_run), .done(a_done), .timeout(a_to), .cycle_cnt(a_cnt));

   sys_reset_seq #(.N_CH(4), .HOLD_CYCLES(8), .STAGGER(2), .CNT_W(32), .TIMEOUT(50)) dut_b (
      .clk(clk), .reset(reset), .soft_rst(soft_rst), .halt(halt_b),
      .rst_out(b_rst), .run(b_run), .done(b_done), .timeout(b_to), .cycle_cnt(b_cnt));

   sys_reset_seq #(.N_CH(1), .HOLD_CYCLES(8), .STAGGER(0), .CNT_W(8), .TIMEOUT(0)) dut_c (
      .clk(clk), .reset(reset), .soft_rst(soft_rst), .halt(halt_c),
      .rst_out(c_rst), .run(c_run), .done(c_done), .timeout(c_to), .cycle_cnt(c_cnt));

   always #5 clk = ~clk;

   // Reference model: k counts edges since T0; releases and run follow directly from k
   function automatic void mreset(int d);
      m[d].in_sync   = 1'b1;
      m[d].since_rel = 0;
      m[d].waiting   = 1'b0;
      m[d].active    = 1'b0;
      m[d].k         = 0;
      m[d].cnt       = 0;
      m[d].done      = 1'b0;
      m[d].to        = 1'b0;
   endfunction

   function automatic bit mrunning(int d);
      return m[d].active && !m[d].done && (m[d].k >= P_H[d] + (P_N[d] - 1) * P_S[d]);
   endfunction

   function automatic void mstep(int d, bit rs, bit s, bit h);
      bit     was_run;
      longint old;
      if (rs) begin
         mreset(d);
         return;
      end
      if (m[d].in_sync) begin
         m[d].since_rel++;
         if (m[d].since_rel == 3) begin
            m[d].in_sync = 1'b0;
            m[d].active  = 1'b1;
            m[d].k       = 0;
         end
         return;
      end
      if (s) begin
         m[d].active  = 1'b0;
         m[d].waiting = 1'b1;
         m[d].cnt     = 0;
         m[d].done    = 1'b0;
         m[d].to      = 1'b0;
         return;
      end
      if (m[d].waiting) begin
         m[d].waiting = 1'b0;
         m[d].active  = 1'b1;
         m[d].k       = 0;
         return;
      end
      was_run = mrunning(d);
      old     = m[d].cnt;
      if (m[d].k < 1000000) m[d].k++;
      if (was_run) begin
         if (old < P_MAX[d]) m[d].cnt = old + 1;
         if (h) m[d].done = 1'b1;
         else if ((P_TO[d] != 0) && (old == longint'(P_TO[d] - 1))) begin
            m[d].done = 1'b1;
            m[d].to   = 1'b1;
         end
      end
   endfunction

   function automatic obs_t mobs(int d);
      obs_t o;
      o.rst = '0;
      for (int i = 0; i < P_N[d]; i++)
         o.rst[i] = !(m[d].active && (m[d].k >= P_H[d] + i * P_S[d]));
      o.run  = mrunning(d);
      o.done = m[d].done;
      o.to   = m[d].to;
      o.cnt  = 32'(m[d].cnt);
      return o;
   endfunction

   function automatic obs_t aobs(int d);
      obs_t o;
      case (d)
         0:       o = {a_rst, a_run, a_done, a_to, a_cnt};
         1:       o = {b_rst, b_run, b_done, b_to, b_cnt};
         default: o = {3'b000, c_rst, c_run, c_done, c_to, 24'd0, c_cnt};
      endcase
      return o;
   endfunction

   function automatic void push_all();
      for (int d = 0; d < ND; d++) q[d].push_back(mobs(d));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input bit s, input bit ha, input bit hb, input bit hc);
      soft_rst = s;
      halt_a   = ha;
      halt_b   = hb;
      halt_c   = hc;
      @(posedge clk);
      mstep(0, reset, s, ha);
      mstep(1, reset, s, hb);
      mstep(2, reset, s, hc);
      push_all();
      #1;
   endtask

   // Async reset pulse placed between clock edges; outputs must clear without an edge
   task automatic reset_pulse();
      soft_rst = 1'b0;
      halt_a   = 1'b0;
      halt_b   = 1'b0;
      halt_c   = 1'b0;
      reset    = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         mreset(d);
         q[d].delete();
      end
      push_all();
      check("async_rst_a_rst_out", 32'(a_rst), 32'hF);
      check("async_rst_a_run",     32'(a_run), 32'h0);
      check("async_rst_a_cnt",     a_cnt,      32'h0);
      check("async_rst_c_rst_out", 32'(c_rst), 32'h1);
      check("async_rst_c_cnt",     32'(c_cnt), 32'h0);
      #1 reset = 1'b0;
   endtask

   function automatic bit rnd_halt(int d, int run_odds);
      if (mrunning(d)) return ($urandom_range(0, run_odds - 1) == 0);
      return ($urandom_range(0, 2) == 0);
   endfunction

   // Scoreboard monitor: one expected snapshot per DUT per edge, compared mid-cycle
   always @(negedge clk) begin
      obs_t e, a;
      for (int d = 0; d < ND; d++) begin
         if (q[d].size() > 0) begin
            e = q[d].pop_front();
            a = aobs(d);
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL sb_dut%0d t=%0t actual rst=%b run=%b done=%b to=%b cnt=%0d required rst=%b run=%b done=%b to=%b cnt=%0d",
                        d, $time, a.rst, a.run, a.done, a.to, a.cnt, e.rst, e.run, e.done, e.to, e.cnt);
            end
         end
      end
   end

   initial begin
      bit s_prev, s;
      reset    = 1'b0;
      soft_rst = 1'b0;
      halt_a   = 1'b0;
      halt_b   = 1'b0;
      halt_c   = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("reset_a_rst_out", 32'(a_rst), 32'hF);
      check("reset_a_run",     32'(a_run), 32'h0);
      check("reset_b_timeout", 32'(b_to),  32'h0);
      check("reset_c_rst_out", 32'(c_rst), 32'h1);
      for (int d = 0; d < ND; d++) mreset(d);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Release order, halt at 100 (A), watchdog (B), counter saturation (C)
      for (int j = 1; j <= 280; j++) begin
         tick(1'b0,
              mrunning(0) ? bit'(m[0].cnt == 100) : bit'($urandom_range(0, 3) == 0),
              mrunning(1) ? 1'b0 : bit'($urandom_range(0, 3) == 0),
              mrunning(2) ? 1'b0 : bit'($urandom_range(0, 3) == 0));
         if (j == 10) check("rel_a_t0p7",  32'(a_rst), 32'hF);
         if (j == 10) check("rel_c_t0p7",  32'(c_rst), 32'h1);
         if (j == 11) check("rel_a_t0p8",  32'(a_rst), 32'hE);
         if (j == 11) check("rel_c_t0p8",  32'(c_rst), 32'h0);
         if (j == 13) check("rel_a_t0p10", 32'(a_rst), 32'hC);
         if (j == 15) check("rel_a_t0p12", 32'(a_rst), 32'h8);
         if (j == 16) check("run_a_t0p13", 32'(a_run), 32'h0);
         if (j == 17) check("rel_a_t0p14", 32'(a_rst), 32'h0);
         if (j == 17) check("run_a_t0p14", 32'(a_run), 32'h1);
         if (j == 18) check("cnt_a_t0p15", a_cnt,      32'h1);
      end
      check("halt_a_cnt",      a_cnt,       32'd101);
      check("halt_a_done",     32'(a_done), 32'h1);
      check("halt_a_timeout",  32'(a_to),   32'h0);
      check("halt_a_rst_out",  32'(a_rst),  32'h0);
      check("wdog_b_cnt",      b_cnt,       32'd50);
      check("wdog_b_timeout",  32'(b_to),   32'h1);
      check("wdog_b_run",      32'(b_run),  32'h0);
      check("sat_c_cnt",       32'(c_cnt),  32'd255);
      check("sat_c_run",       32'(c_run),  32'h1);

      // Soft reset from DONE, then halt/watchdog tie on B
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("soft_a_rst_out", 32'(a_rst), 32'hF);
      check("soft_a_done",    32'(a_done), 32'h0);
      check("soft_a_cnt",     a_cnt,       32'h0);
      for (int j = 1; j <= 120; j++) begin
         tick(1'b0, rnd_halt(0, 40),
              mrunning(1) ? bit'(m[1].cnt == 49) : bit'($urandom_range(0, 3) == 0),
              rnd_halt(2, 30));
         if (j == 8)  check("soft_rel_a_t0p7",  32'(a_rst), 32'hF);
         if (j == 9)  check("soft_rel_a_t0p8",  32'(a_rst), 32'hE);
         if (j == 15) check("soft_rel_a_t0p14", 32'(a_rst), 32'h0);
         if (j == 15) check("soft_run_a",       32'(a_run), 32'h1);
      end
      check("tie_b_cnt",     b_cnt,       32'd50);
      check("tie_b_done",    32'(b_done), 32'h1);
      check("tie_b_timeout", 32'(b_to),   32'h0);

      // Random soft_rst / halt traffic in every state
      s_prev = 1'b0;
      for (int j = 1; j <= 250; j++) begin
         s = ($urandom_range(0, 19) == 0) || (s_prev && ($urandom_range(0, 1) == 1));
         tick(s, rnd_halt(0, 25), rnd_halt(1, 25), rnd_halt(2, 25));
         s_prev = s;
      end

      // Async reset pulses: from arbitrary state, mid-HOLD with channels partly released, early HOLD
      reset_pulse();
      for (int j = 1; j <= 13; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_pulse_a_rst_out", 32'(a_rst), 32'hC);
      reset_pulse();
      for (int j = 1; j <= 9; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      reset_pulse();
      for (int j = 1; j <= 40; j++) begin
         tick(1'b0, rnd_halt(0, 30), rnd_halt(1, 30), rnd_halt(2, 30));
         if (j == 10) check("c_rel_t0p7", 32'(c_rst), 32'h1);
         if (j == 11) check("c_rel_t0p8", 32'(c_rst), 32'h0);
         if (j == 11) check("c_run_t0p8", 32'(c_run), 32'h1);
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
